encoder_8b_10b: RTL and testbench



---
 rtl/encoder_8b_10b_pkg.sv | 36 +++
 rtl/encoder_8b_10b_lut.sv | 52 +++++
 rtl/encoder_8b_10b.sv | 88 ++++++++
 tb/tb_encoder_8b_10b.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/encoder_8b_10b_pkg.sv
// rtl/encoder_8b_10b_pkg.sv - 8b/10b code tables and constants (RD- forms, abcdei_fghj order)
package encoder_8b_10b_pkg;

    localparam logic [9:0] K28_7_RDN          = 10'b0011111000;
    localparam logic [9:0] K28_7_RDP          = 10'b1100000111;
    localparam logic [7:0] K28_7_BYTE_DEFAULT = 8'hFC;

    // Indexed by EDCBA; abcdei with a at bit 5. Unbalanced entries carry +2.
    localparam logic [5:0] ENC6_RDN [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001,
        6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100,
        6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010,
        6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110,
        6'b001110, 6'b101110, 6'b011110, 6'b101011
    };

    // Indexed by HGF; fghj with f at bit 3. Entry 7 is the primary P7 form.
    localparam logic [3:0] ENC4_RDN [8] = '{
        4'b1011, 4'b1001, 4'b0101, 4'b1100,
        4'b1101, 4'b1010, 4'b0110, 4'b1110
    };

    localparam logic [3:0] A7_RDN = 4'b0111;

    // Bit n set means EDCBA == n selects A7 at that running disparity.
    localparam logic [31:0] A7_SET_RDN = 32'h0016_0000;
    localparam logic [31:0] A7_SET_RDP = 32'h0000_6800;

    function automatic logic use_a7(input logic rd, input logic [4:0] edcba);
        return rd ? A7_SET_RDP[edcba] : A7_SET_RDN[edcba];
    endfunction

endpackage

// File: rtl/encoder_8b_10b_lut.sv
// rtl/encoder_8b_10b_lut.sv - combinational 5b/6b + 3b/4b encode with disparity selection
module encoder_8b_10b_lut
    import encoder_8b_10b_pkg::*;
#(
    parameter logic [7:0] K28_7_BYTE = K28_7_BYTE_DEFAULT
) (
    input  logic [7:0] data,
    input  logic       is_k,
    input  logic       rd_in,
    output logic [9:0] code10,
    output logic       rd_out,
    output logic       k_err
);

    logic [5:0] t6;
    logic [5:0] c6;
    logic [3:0] t4;
    logic [3:0] c4;
    logic       rd6;
    logic       rd4;

    always_comb begin
        t6  = ENC6_RDN[data[4:0]];
        c6  = t6;
        // D.7 is balanced but still has a distinct RD+ form
        if (rd_in && (($countones(t6) != 3) || (data[4:0] == 5'd7))) begin
            c6 = ~t6;
        end
        rd6 = ($countones(t6) == 3) ? rd_in : ~rd_in;

        t4 = ENC4_RDN[data[7:5]];
        if ((data[7:5] == 3'd7) && use_a7(rd6, data[4:0])) begin
            t4 = A7_RDN;
        end
        c4 = t4;
        if (rd6 && (($countones(t4) != 2) || (data[7:5] == 3'd3))) begin
            c4 = ~t4;
        end
        rd4 = ($countones(t4) == 2) ? rd6 : ~rd6;

        if (is_k) begin
            code10 = rd_in ? K28_7_RDP : K28_7_RDN;
            rd_out = rd_in;
            k_err  = (data != K28_7_BYTE);
        end else begin
            code10 = {c6, c4};
            rd_out = rd4;
            k_err  = 1'b0;
        end
    end

endmodule

// File: rtl/encoder_8b_10b.sv
// rtl/encoder_8b_10b.sv - 8b/10b transmit encoder with valid/ready output register and RD tracking
module encoder_8b_10b
    import encoder_8b_10b_pkg::*;
#(
    parameter bit         IDLE_FILL  = 1'b1,
    parameter logic [7:0] K28_7_BYTE = K28_7_BYTE_DEFAULT
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [7:0] s_data,
    input  logic       s_is_k,
    input  logic       s_valid,
    output logic       s_ready,
    output logic [9:0] m_code,
    output logic       m_valid,
    input  logic       m_ready,
    output logic       m_rd,
    output logic       k_err
);

    logic [9:0] m_code_q,  m_code_d;
    logic       m_valid_q, m_valid_d;
    logic       rd_q,      rd_d;
    logic       k_err_q,   k_err_d;

    logic       load;
    logic [7:0] lut_data;
    logic       lut_is_k;
    logic [9:0] lut_code;
    logic       lut_rd;
    logic       lut_k_err;

    assign load    = !m_valid_q || m_ready;
    assign s_ready = load;

    // With no input beat the LUT is steered to K28.7 for idle fill
    assign lut_data = s_valid ? s_data : K28_7_BYTE;
    assign lut_is_k = s_valid ? s_is_k : 1'b1;

    encoder_8b_10b_lut #(
        .K28_7_BYTE (K28_7_BYTE)
    ) u_lut (
        .data   (lut_data),
        .is_k   (lut_is_k),
        .rd_in  (rd_q),
        .code10 (lut_code),
        .rd_out (lut_rd),
        .k_err  (lut_k_err)
    );

    always_comb begin
        m_code_d  = m_code_q;
        m_valid_d = m_valid_q;
        rd_d      = rd_q;
        k_err_d   = k_err_q;
        if (load) begin
            if (s_valid || IDLE_FILL) begin
                m_code_d  = lut_code;
                m_valid_d = 1'b1;
                rd_d      = lut_rd;
                k_err_d   = lut_k_err;
            end else begin
                m_valid_d = 1'b0;
                k_err_d   = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_code_q  <= '0;
            m_valid_q <= 1'b0;
            rd_q      <= 1'b0;
            k_err_q   <= 1'b0;
        end else begin
            m_code_q  <= m_code_d;
            m_valid_q <= m_valid_d;
            rd_q      <= rd_d;
            k_err_q   <= k_err_d;
        end
    end

    assign m_code  = m_code_q;
    assign m_valid = m_valid_q;
    assign m_rd    = rd_q;
    assign k_err   = k_err_q;

endmodule

// File: tb/tb_encoder_8b_10b.sv
// tb/tb_encoder_8b_10b.sv - randomized self-checking bench for encoder_8b_10b against a disparity model
module tb_encoder_8b_10b;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [7:0] s_data = 8'h00;
    logic       s_is_k = 1'b0;
    logic       s_valid = 1'b0;
    logic       s_ready;
    logic [9:0] m_code;
    logic       m_valid;
    logic       m_ready = 1'b1;
    logic       m_rd;
    logic       k_err;

    int total = 0;
    int bad   = 0;

    bit         e_valid = 1'b0;
    logic [9:0] e_code  = '0;
    int         e_rd    = -1;
    bit         e_kerr  = 1'b0;
    int         accepted_data = 0;
    int         seen_data     = 0;

    localparam logic [9:0] KRDN = 10'b0011111000;
    localparam logic [9:0] KRDP = 10'b1100000111;

    localparam logic [5:0] T6 [32] = '{
        6'b100111, 6'b011101, 6'b101101, 6'b110001, 6'b110101, 6'b101001, 6'b011001, 6'b111000,
        6'b111001, 6'b100101, 6'b010101, 6'b110100, 6'b001101, 6'b101100, 6'b011100, 6'b010111,
        6'b011011, 6'b100011, 6'b010011, 6'b110010, 6'b001011, 6'b101010, 6'b011010, 6'b111010,
        6'b110011, 6'b100110, 6'b010110, 6'b110110, 6'b001110, 6'b101110, 6'b011110, 6'b101011
    };
    localparam logic [3:0] T4 [8] = '{
        4'b1011, 4'b1001, 4'b0101, 4'b1100, 4'b1101, 4'b1010, 4'b0110, 4'b1110
    };

    always #5 clk = ~clk;

    encoder_8b_10b #(
        .IDLE_FILL  (1'b1),
        .K28_7_BYTE (8'hFC)
    ) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .s_data  (s_data),
        .s_is_k  (s_is_k),
        .s_valid (s_valid),
        .s_ready (s_ready),
        .m_code  (m_code),
        .m_valid (m_valid),
        .m_ready (m_ready),
        .m_rd    (m_rd),
        .k_err   (k_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Running disparity kept as -1/+1; each sub-block picks the form that pulls it back toward zero
    function automatic void enc(input logic [7:0] d, input bit k, input int rd,
                                output logic [9:0] code, output int rd_o, output bit kerr);
        logic [5:0] six;
        logic [3:0] four;
        int x, y, d6, d4, rd1;
        x    = int'(d[4:0]);
        y    = int'(d[7:5]);
        kerr = 1'b0;
        if (k) begin
            code = (rd < 0) ? KRDN : KRDP;
            rd_o = rd;
            kerr = (d != 8'hFC);
            return;
        end
        six = T6[x];
        d6  = 2 * $countones(six) - 6;
        if (d6 * rd > 0 || (x == 7 && rd > 0)) begin
            six = ~six;
            d6  = -d6;
        end
        rd1  = rd + d6;
        four = T4[y];
        if (y == 7 && ((rd1 < 0 && (x == 17 || x == 18 || x == 20)) ||
                       (rd1 > 0 && (x == 11 || x == 13 || x == 14))))
            four = 4'b0111;
        d4 = 2 * $countones(four) - 4;
        if (d4 * rd1 > 0 || (y == 3 && rd1 > 0)) begin
            four = ~four;
            d4   = -d4;
        end
        rd_o = rd1 + d4;
        code = {six, four};
    endfunction

    task automatic cycle();
        bit         exp_ready;
        logic [9:0] c;
        int         r;
        bit         ke;
        #1;
        exp_ready = !e_valid || m_ready;
        chk("s_ready", s_ready, exp_ready);
        if (m_valid && m_ready && m_code != KRDN && m_code != KRDP) seen_data++;
        if (exp_ready) begin
            if (s_valid) begin
                enc(s_data, s_is_k, e_rd, c, r, ke);
                if (!s_is_k) accepted_data++;
            end else begin
                enc(8'hFC, 1'b1, e_rd, c, r, ke);
            end
            e_code  = c;
            e_rd    = r;
            e_kerr  = ke;
            e_valid = 1'b1;
        end
        @(posedge clk);
        #1;
        chk("m_valid", m_valid, e_valid);
        chk("m_code", m_code, e_code);
        chk("m_rd", m_rd, (e_rd > 0));
        chk("k_err", k_err, e_kerr);
    endtask

    task automatic send(input logic [7:0] d, input bit k);
        s_valid = 1'b1;
        s_data  = d;
        s_is_k  = k;
        cycle();
        s_valid = 1'b0;
        s_is_k  = 1'b0;
    endtask

    initial begin
        int sent;
        int guard;
        logic [9:0] held;

        repeat (2) @(posedge clk);
        #1;
        chk("rst_m_valid", m_valid, 0);
        chk("rst_m_code", m_code, 0);
        chk("rst_m_rd", m_rd, 0);
        chk("rst_k_err", k_err, 0);

        rst_n = 1'b1;
        repeat (4) begin
            cycle();
            chk("idle_code", m_code, KRDN);
            chk("idle_rd", m_rd, 0);
        end

        send(8'h03, 1'b0);
        chk("d3_0_a", {m_rd, m_code}, {1'b1, 10'b1100011011});
        send(8'h03, 1'b0);
        chk("d3_0_b", {m_rd, m_code}, {1'b0, 10'b1100010100});
        send(8'h00, 1'b0);
        chk("d0_0", {m_rd, m_code}, {1'b0, 10'b1001110100});
        send(8'hF1, 1'b0);
        chk("d17_7_a7", {m_rd, m_code}, {1'b1, 10'b1000110111});
        send(8'hE7, 1'b0);
        chk("d7_7_rdp", {m_rd, m_code}, {1'b0, 10'b0001110001});

        held    = e_code;
        m_ready = 1'b0;
        s_valid = 1'b1;
        s_data  = 8'hAA;
        repeat (5) begin
            cycle();
            chk("stall_code", m_code, held);
        end
        m_ready = 1'b1;
        cycle();
        s_valid = 1'b0;
        cycle();

        sent  = 0;
        guard = 0;
        while (sent < 100 && guard < 3000) begin
            m_ready = ($urandom_range(0, 3) != 0);
            s_valid = ($urandom_range(0, 3) != 0);
            s_data  = 8'($urandom);
            s_is_k  = ($urandom_range(0, 15) == 0);
            if (s_is_k && $urandom_range(0, 1) == 0) s_data = 8'hFC;
            if (s_valid && (!e_valid || m_ready)) sent++;
            cycle();
            guard++;
        end
        chk("rand_done", (sent >= 100), 1);
        s_valid = 1'b0;
        s_is_k  = 1'b0;
        m_ready = 1'b1;
        repeat (3) cycle();
        chk("beat_count", seen_data, accepted_data);

        if (e_rd < 0) send(8'h03, 1'b0);
        send(8'hBC, 1'b1);
        chk("kerr_set", k_err, 1);
        chk("kerr_code", m_code, KRDP);
        cycle();
        chk("kerr_clear", k_err, 0);

        #3;
        rst_n = 1'b0;
        #1;
        chk("async_rst_valid", m_valid, 0);
        chk("async_rst_rd", m_rd, 0);
        chk("async_rst_code", m_code, 0);
        e_valid = 1'b0;
        e_code  = '0;
        e_rd    = -1;
        e_kerr  = 1'b0;
        #2;
        rst_n = 1'b1;
        cycle();
        chk("post_rst_code", m_code, KRDN);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
